// File: rtl/id_exe_pipe.sv
// ID/EX pipeline register with valid bit, downstream hold, flush-to-bubble and a
// load-use detector (enabled by defining ID_EXE_LOAD_USE_EN) with a saturating bubble counter.
module id_exe_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic [DATA_W-1:0] dpc4,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] ext_imm,
    input  logic [REG_AW-1:0] rw,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [OP_W-1:0]   aluop,
    input  logic              s_b,
    input  logic              reg_write,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [1:0]        s_data_write,
    output logic [DATA_W-1:0] ddpc4,
    output logic [DATA_W-1:0] ddata1,
    output logic [DATA_W-1:0] ddata2,
    output logic [DATA_W-1:0] dext_imm,
    output logic [REG_AW-1:0] drw,
    output logic [REG_AW-1:0] nrs,
    output logic [REG_AW-1:0] nrt,
    output logic [OP_W-1:0]   naluop,
    output logic              ns_b,
    output logic              nreg_write,
    output logic              nmem_write,
    output logic              nmem_read,
    output logic [1:0]        ns_data_write,
    output logic              nvalid,
    output logic              id_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic load_use;
    logic kill_ctrl;
    logic cnt_full;

`ifdef ID_EXE_LOAD_USE_EN
    // A live load in EX whose destination is read by the live ID instruction.
    assign load_use = nvalid & nmem_read & nreg_write & (drw != '0) &
                      ((drw == rs) | (drw == rt)) & in_valid & ~flush;
`else
    assign load_use = 1'b0;
`endif

    assign id_stall  = ex_stall | load_use;
    assign kill_ctrl = flush | load_use | ~in_valid;
    assign cnt_full  = &bubble_cnt;

    // Data group: held on downstream stall and while a load-use bubble is inserted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ddpc4    <= '0;
            ddata1   <= '0;
            ddata2   <= '0;
            dext_imm <= '0;
            drw      <= '0;
            nrs      <= '0;
            nrt      <= '0;
        end else if (!ex_stall && !load_use) begin
            ddpc4    <= dpc4;
            ddata1   <= data1;
            ddata2   <= data2;
            dext_imm <= ext_imm;
            drw      <= rw;
            nrs      <= rs;
            nrt      <= rt;
        end
    end

    // Control group: a bubble always clears every control bit so later stages need no gating.
    always_ff @(posedge clock) begin
        if (!reset) begin
            nvalid        <= 1'b0;
            nreg_write    <= 1'b0;
            nmem_write    <= 1'b0;
            nmem_read     <= 1'b0;
            ns_b          <= 1'b0;
            ns_data_write <= '0;
            naluop        <= '0;
        end else if (!ex_stall) begin
            if (kill_ctrl) begin
                nvalid        <= 1'b0;
                nreg_write    <= 1'b0;
                nmem_write    <= 1'b0;
                nmem_read     <= 1'b0;
                ns_b          <= 1'b0;
                ns_data_write <= '0;
                naluop        <= '0;
            end else begin
                nvalid        <= 1'b1;
                nreg_write    <= reg_write;
                nmem_write    <= mem_write;
                nmem_read     <= mem_read;
                ns_b          <= s_b;
                ns_data_write <= s_data_write;
                naluop        <= aluop;
            end
        end
    end

    // Counts only bubbles actually inserted; a held stage inserts nothing.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (!ex_stall && load_use && !cnt_full) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_exe_pipe.sv
// Scoreboard bench for id_exe_pipe: directed hazard scenarios plus random traffic,
// checked against a transaction-level model of the ID/EX entry.
module tb_id_exe_pipe;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int OP_W   = 5;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic              reset;
        logic              in_valid;
        logic              flush;
        logic              ex_stall;
        logic [DATA_W-1:0] dpc4;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] ext_imm;
        logic [REG_AW-1:0] rw;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [OP_W-1:0]   aluop;
        logic              s_b;
        logic              reg_write;
        logic              mem_write;
        logic              mem_read;
        logic [1:0]        sdw;
    } stim_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] dpc4;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] ext_imm;
        logic [REG_AW-1:0] rw;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [OP_W-1:0]   aluop;
        logic              s_b;
        logic              reg_write;
        logic              mem_write;
        logic              mem_read;
        logic [1:0]        sdw;
        logic [CNT_W-1:0]  cnt;
        logic              dk;
    } ex_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    stim_t cur;
    ex_t   st;
    ex_t   exp_q[$];
    logic  stall_q[$];
    logic  known;
    logic  last_stall;
    int    total = 0;
    int    bad   = 0;

    logic [DATA_W-1:0] ddpc4, ddata1, ddata2, dext_imm;
    logic [REG_AW-1:0] drw, nrs, nrt;
    logic [OP_W-1:0]   naluop;
    logic              ns_b, nreg_write, nmem_write, nmem_read, nvalid, id_stall;
    logic [1:0]        ns_data_write;
    logic [CNT_W-1:0]  bubble_cnt;

    id_exe_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(cur.reset), .in_valid(cur.in_valid), .flush(cur.flush),
        .ex_stall(cur.ex_stall), .dpc4(cur.dpc4), .data1(cur.data1), .data2(cur.data2),
        .ext_imm(cur.ext_imm), .rw(cur.rw), .rs(cur.rs), .rt(cur.rt), .aluop(cur.aluop),
        .s_b(cur.s_b), .reg_write(cur.reg_write), .mem_write(cur.mem_write),
        .mem_read(cur.mem_read), .s_data_write(cur.sdw),
        .ddpc4(ddpc4), .ddata1(ddata1), .ddata2(ddata2), .dext_imm(dext_imm),
        .drw(drw), .nrs(nrs), .nrt(nrt), .naluop(naluop), .ns_b(ns_b),
        .nreg_write(nreg_write), .nmem_write(nmem_write), .nmem_read(nmem_read),
        .ns_data_write(ns_data_write), .nvalid(nvalid), .id_stall(id_stall),
        .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // Hazard rule: EX has a live load writing a nonzero register that the live, unflushed ID reads.
    function automatic logic model_lu(ex_t s, stim_t x);
`ifdef ID_EXE_LOAD_USE_EN
        return x.in_valid && !x.flush && s.valid && s.mem_read && s.reg_write &&
               s.rw != 0 && (s.rw == x.rs || s.rw == x.rt);
`else
        return 1'b0;
`endif
    endfunction

    function automatic ex_t model_next(ex_t s, stim_t x);
        ex_t n = s;
        logic take_data, live;
        if (!x.reset) begin
            n = '0;
            n.dk = 1'b1;
            return n;
        end
        if (x.ex_stall) return s;
        take_data = !model_lu(s, x);
        live      = x.in_valid && !x.flush && !model_lu(s, x);
        if (take_data) begin
            n.dpc4 = x.dpc4; n.data1 = x.data1; n.data2 = x.data2; n.ext_imm = x.ext_imm;
            n.rw = x.rw; n.rs = x.rs; n.rt = x.rt;
            n.dk = !x.flush;
        end
        n.valid     = live;
        n.reg_write = live ? x.reg_write : 1'b0;
        n.mem_write = live ? x.mem_write : 1'b0;
        n.mem_read  = live ? x.mem_read  : 1'b0;
        n.s_b       = live ? x.s_b       : 1'b0;
        n.sdw       = live ? x.sdw       : 2'd0;
        n.aluop     = live ? x.aluop     : '0;
        if (model_lu(s, x) && int'(s.cnt) < (1 << CNT_W) - 1) n.cnt = s.cnt + 1'b1;
        return n;
    endfunction

    function automatic stim_t rand_stim();
        stim_t x;
        x.reset     = 1'b1;
        x.in_valid  = ($urandom_range(0, 7) != 0);
        x.flush     = ($urandom_range(0, 7) == 0);
        x.ex_stall  = ($urandom_range(0, 5) == 0);
        x.dpc4      = $urandom;
        x.data1     = $urandom;
        x.data2     = $urandom;
        x.ext_imm   = $urandom;
        x.rw        = REG_AW'($urandom_range(0, 3));
        x.rs        = REG_AW'($urandom_range(0, 3));
        x.rt        = REG_AW'($urandom_range(0, 3));
        x.aluop     = OP_W'($urandom);
        x.s_b       = 1'($urandom);
        x.reg_write = 1'($urandom);
        x.mem_write = 1'($urandom);
        x.mem_read  = 1'($urandom);
        x.sdw       = 2'($urandom);
        return x;
    endfunction

    // Non-load instruction whose registers stay clear of the directed hazard registers.
    function automatic stim_t plain();
        stim_t x = rand_stim();
        x.in_valid = 1'b1; x.flush = 1'b0; x.ex_stall = 1'b0; x.mem_read = 1'b0;
        x.rw = REG_AW'($urandom_range(16, 31));
        x.rs = REG_AW'($urandom_range(16, 31));
        x.rt = REG_AW'($urandom_range(16, 31));
        return x;
    endfunction

    function automatic stim_t load(input logic [REG_AW-1:0] dst);
        stim_t x = plain();
        x.mem_read = 1'b1; x.reg_write = 1'b1; x.rw = dst;
        return x;
    endfunction

    task automatic issue(input stim_t x);
        ex_t nx;
        cur = x;
        last_stall = x.ex_stall | model_lu(st, x);
        if (known) stall_q.push_back(last_stall);
        nx = model_next(st, x);
        exp_q.push_back(nx);
        st = nx;
        known = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        ex_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("nvalid",        32'(nvalid),        32'(e.valid));
                chk("nreg_write",    32'(nreg_write),    32'(e.reg_write));
                chk("nmem_write",    32'(nmem_write),    32'(e.mem_write));
                chk("nmem_read",     32'(nmem_read),     32'(e.mem_read));
                chk("ns_b",          32'(ns_b),          32'(e.s_b));
                chk("ns_data_write", 32'(ns_data_write), 32'(e.sdw));
                chk("naluop",        32'(naluop),        32'(e.aluop));
                chk("bubble_cnt",    32'(bubble_cnt),    32'(e.cnt));
                if (e.dk) begin
                    chk("ddpc4",    ddpc4,       e.dpc4);
                    chk("ddata1",   ddata1,      e.data1);
                    chk("ddata2",   ddata2,      e.data2);
                    chk("dext_imm", dext_imm,    e.ext_imm);
                    chk("drw",      32'(drw),    32'(e.rw));
                    chk("nrs",      32'(nrs),    32'(e.rs));
                    chk("nrt",      32'(nrt),    32'(e.rt));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (stall_q.size() > 0) chk("id_stall", 32'(id_stall), 32'(stall_q.pop_front()));
        end
    end

    initial begin
        stim_t x, y, prev;
        known = 1'b0;
        last_stall = 1'b0;
        st = '0;
        cur = '0;
        @(negedge clock);

        // Reset held over two edges with every input nonzero.
        for (int i = 0; i < 2; i++) begin
            x = rand_stim();
            x.reset = 1'b0; x.in_valid = 1'b1; x.flush = 1'b1; x.ex_stall = 1'(i);
            x.rw = x.rw | 5'd1; x.rs = x.rs | 5'd1; x.rt = x.rt | 5'd1;
            x.dpc4 = x.dpc4 | 1; x.data1 = x.data1 | 1; x.data2 = x.data2 | 1;
            x.ext_imm = x.ext_imm | 1; x.aluop = x.aluop | 5'd1; x.sdw = 2'd3;
            x.s_b = 1'b1; x.reg_write = 1'b1; x.mem_write = 1'b1; x.mem_read = 1'b1;
            issue(x);
        end

        x = plain(); x.data1 = 32'h1234; issue(x);

        // Load-use on rs, then the same shape with r0 as destination.
        issue(load(5'd8));
        y = plain(); y.rs = 5'd8; issue(y); issue(y);
        issue(load(5'd0));
        y = plain(); y.rs = 5'd0; issue(y);

        // Flush beats the hazard.
        issue(load(5'd8));
        y = plain(); y.rs = 5'd8; y.flush = 1'b1; issue(y);
        y.flush = 1'b0; issue(y);

        // Downstream hold over an active hazard, inputs changing.
        issue(load(5'd5));
        for (int i = 0; i < 3; i++) begin
            y = plain(); y.rt = 5'd5; y.ex_stall = 1'b1; issue(y);
        end
        y.ex_stall = 1'b0; issue(y); issue(y);

        // Enough hazards to saturate the counter.
        for (int i = 0; i < 18; i++) begin
            issue(load(5'd3));
            y = plain(); y.rt = 5'd3; issue(y); issue(y);
        end

        prev = plain();
        for (int i = 0; i < 600; i++) begin
            x = rand_stim();
            x.reset = ($urandom_range(0, 49) != 0);
            if (last_stall) begin
                y = prev;
                y.ex_stall = x.ex_stall;
                y.reset = x.reset;
                x = y;
            end
            prev = x;
            issue(x);
        end

        repeat (3) @(negedge clock);
        chk("queues_drained", 32'(exp_q.size() + stall_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_exe_pipe.md
# id_exe_pipe

Parametrised ID/EX pipeline stage register for the five-stage pipeline CPU, replacing the fixed-width per-field register bank between decode and execute. Adds a per-stage valid bit, a downstream hold, a flush that turns the entry into a bubble, and an optional load-use hazard detector. The detector stalls IF/ID and inserts one bubble into EX. A saturating counter records inserted load-use bubbles for performance analysis.

## Interface
- DATA_W, 32, width of pc+4, operand and immediate fields
- REG_AW, 5, register-address width (rs, rt, rw)
- OP_W, 5, ALU opcode width
- CNT_W, 16, bubble-counter width
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock
- in_valid  in  1  ID holds a real instruction
- flush  in  1  kill the ID instruction (taken branch/jump); EX receives a bubble
- ex_stall  in  1  downstream cannot advance; stage holds
- dpc4, data1, data2, ext_imm  in  DATA_W each  decoded datapath fields
- rw, rs, rt  in  REG_AW each  destination and source register numbers
- aluop  in  OP_W  ALU operation
- s_b, reg_write, mem_write, mem_read  in  1 each  control bits (mem_read marks a load)
- s_data_write  in  2  writeback source select
- ddpc4, ddata1, ddata2, dext_imm  out  DATA_W  registered datapath fields
- drw, nrs, nrt  out  REG_AW  registered register numbers
- naluop  out  OP_W  registered ALU operation
- ns_b, nreg_write, nmem_write, nmem_read  out  1  registered control bits
- ns_data_write  out  2  registered writeback select
- nvalid  out  1  EX holds a real instruction
- id_stall  out  1  combinational; freeze PC and IF/ID this cycle
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted

## Operation
- Control group: nreg_write, nmem_write, nmem_read, ns_b, ns_data_write, naluop, nvalid.
- Data group: all other registered outputs.
- load_use = nvalid & nmem_read & nreg_write & (drw != 0) & ((drw == rs) | (drw == rt)) & in_valid & ~flush.
- id_stall = ex_stall | load_use.
- Per rising edge, in priority order:
  - reset low: every output register cleared to 0, bubble_cnt = 0.
  - ex_stall: all registers hold. bubble_cnt unchanged, even if load_use.
  - flush: control group cleared to 0. Data group loads inputs; their values are don't-care.
  - load_use: control group cleared to 0. Data group holds. bubble_cnt increments, saturating at 2^CNT_W-1.
  - otherwise: all fields load their inputs. nvalid = in_valid. If in_valid = 0, the control group is cleared to 0.
- A bubble (nvalid = 0) never carries reg_write or mem_write = 1. Downstream stages need no extra gating.
- After a load-use bubble, the load has left EX, so load_use deasserts. The held ID instruction enters EX on the next cycle. Every load-use hazard costs exactly one cycle.

## Timing
- Latency: 1 cycle from inputs to registered outputs.
- id_stall is combinational from ex_stall, flush, in_valid, rs, rt and registered state. No registered path to IF/ID.
- Reset: outputs read 0 from the first edge with reset low until the first edge with reset high. An operation in progress when reset is asserted is discarded, including any pending bubble.
- Simultaneous events:
  - flush + load_use: flush wins. No stall, no count.
  - ex_stall + flush: hold. The controller keeps flush asserted until ex_stall drops.
- Counter saturation: at all-ones, further bubbles leave bubble_cnt unchanged. It never wraps.

## Configuration
- ID_EXE_LOAD_USE_EN
  - Defined: load-use detection as above.
  - Undefined: load_use is tied to 0, id_stall = ex_stall, and bubble_cnt stays 0. The register bank, flush and hold are unchanged. Forwarding or software then covers load-use.

## Test plan
- Reset: drive all inputs nonzero, reset = 0 for 2 edges. All outputs = 0 and id_stall = ex_stall. Release reset, then one load with in_valid = 1 and data1 = 32'h1234: ddata1 = 32'h1234 and nvalid = 1 after 1 edge.
- Load-use: EX holds a load with drw = 8 (nvalid = 1, nmem_read = 1, nreg_write = 1), ID has rs = 8. id_stall = 1 for 1 cycle, next nvalid = 0, bubble_cnt = 1. ID instruction enters EX the following edge. Repeat with drw = 0: no stall.
- Flush vs hazard: the same hazard with flush = 1. id_stall = 0, nvalid = 0, nreg_write = 0, bubble_cnt unchanged.
- Hold: ex_stall = 1 for 3 cycles with changing inputs and an active hazard. Outputs frozen and bubble_cnt unchanged. After release, the pending bubble is inserted.
- Saturation: CNT_W = 2, force 5 hazards. bubble_cnt = 3 after the third and stays 3.
- Macro off: the same hazard stimulus gives id_stall = 0, the load-dependent instruction loads directly, and bubble_cnt = 0.
